// File: rtl/bnn_pipelined_core.sv
// -----------------------------------------------------------------------------
// bnn_pipelined_core
// Two-layer binary neural network (hidden + output) with a serially loaded
// parameter chain and a three-stage registered pipeline (input, hidden,
// output). A neuron fires when popcount(XNOR(w, in)) >= thr. With
// N_HIDDEN = 0 the hidden stage is removed and the output neurons read the
// registered input directly (two-stage pipeline).
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   setup      1 = shift parameters in, 0 = run
//   param_in   serial parameter bit (shifted in while setup = 1)
//   param_out  top bit of the parameter chain, for daisy-chaining cores
//   in_valid   x is valid this cycle (ignored while setup = 1)
//   x          input vector
//   out_valid  y is valid
//   y          output activations
//   cfg_done   a full chain's worth of bits was loaded in this setup session
//
// Chain layout: hidden neuron k at [k*NB_H +: NB_H], output neuron j at
// [N_HIDDEN*NB_H + j*NB_O +: NB_O]; inside a neuron the weights sit in the
// low bits (w[i] pairs with input i) and the threshold in the high bits.
// -----------------------------------------------------------------------------
module bnn_pipelined_core #(
  parameter int N_IN     = 8,
  parameter int N_HIDDEN = 4,
  parameter int N_OUT    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              setup,
  input  logic              param_in,
  output logic              param_out,
  input  logic              in_valid,
  input  logic [N_IN-1:0]   x,
  output logic              out_valid,
  output logic [N_OUT-1:0]  y,
  output logic              cfg_done
);

  localparam int FI_O  = (N_HIDDEN == 0) ? N_IN : N_HIDDEN;
  localparam int TW_H  = $clog2(N_IN + 1);
  localparam int TW_O  = $clog2(FI_O + 1);
  localparam int NB_H  = N_IN + TW_H;
  localparam int NB_O  = FI_O + TW_O;
  localparam int TOTAL = N_HIDDEN * NB_H + N_OUT * NB_O;
  localparam int OBASE = N_HIDDEN * NB_H;
  localparam int CW    = $clog2(TOTAL + 1);

  // Hidden neuron: count agreeing weight/input bits, fire at or above thr.
  function automatic logic fire_hidden(input logic [N_IN-1:0] w,
                                       input logic [TW_H-1:0] thr,
                                       input logic [N_IN-1:0] v);
    logic [N_IN-1:0] m;
    logic [TW_H-1:0] cnt;
    m   = ~(w ^ v);
    cnt = {TW_H{1'b0}};
    for (int i = 0; i < N_IN; i++) cnt = cnt + TW_H'(m[i]);
    return (cnt >= thr);
  endfunction

  // Output neuron: same rule over the output-layer fan-in.
  function automatic logic fire_output(input logic [FI_O-1:0] w,
                                       input logic [TW_O-1:0] thr,
                                       input logic [FI_O-1:0] v);
    logic [FI_O-1:0] m;
    logic [TW_O-1:0] cnt;
    m   = ~(w ^ v);
    cnt = {TW_O{1'b0}};
    for (int i = 0; i < FI_O; i++) cnt = cnt + TW_O'(m[i]);
    return (cnt >= thr);
  endfunction

  logic [TOTAL-1:0] chain_r;
  logic [CW-1:0]    cfg_cnt_r;
  logic [CW-1:0]    cfg_cnt_next_s;
  logic             cfg_done_r;
  logic             setup_q_r;
  logic [N_IN-1:0]  x_q_r;
  logic             v0_r;
  logic [FI_O-1:0]  o_in_s;
  logic             o_vin_s;
  logic [N_OUT-1:0] y_next_s;
  logic [N_OUT-1:0] y_r;
  logic             out_valid_r;

  assign param_out = chain_r[TOTAL-1];
  assign cfg_done  = cfg_done_r;
  assign y         = y_r;
  assign out_valid = out_valid_r;

  // Session bit counter: a rising setup restarts at 1, then saturates at TOTAL.
  always_comb begin
    cfg_cnt_next_s = cfg_cnt_r;
    if (setup) begin
      if (!setup_q_r) begin
        cfg_cnt_next_s = CW'(1);
      end else if (cfg_cnt_r != CW'(TOTAL)) begin
        cfg_cnt_next_s = cfg_cnt_r + CW'(1);
      end else begin
        cfg_cnt_next_s = cfg_cnt_r;
      end
    end else begin
      cfg_cnt_next_s = cfg_cnt_r;
    end
  end

  // Parameter chain shift, session tracking and registered cfg_done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_r    <= {TOTAL{1'b0}};
      cfg_cnt_r  <= {CW{1'b0}};
      cfg_done_r <= 1'b0;
      setup_q_r  <= 1'b0;
    end else begin
      setup_q_r  <= setup;
      cfg_cnt_r  <= cfg_cnt_next_s;
      cfg_done_r <= (cfg_cnt_next_s == CW'(TOTAL));
      if (setup) begin
        chain_r <= {chain_r[TOTAL-2:0], param_in};
      end
    end
  end

  // Stage 0: capture x; setup drops any vector in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q_r <= {N_IN{1'b0}};
      v0_r  <= 1'b0;
    end else if (setup) begin
      v0_r  <= 1'b0;
    end else begin
      v0_r <= in_valid;
      if (in_valid) begin
        x_q_r <= x;
      end
    end
  end

  generate
    if (N_HIDDEN > 0) begin : g_hidden
      logic [N_HIDDEN-1:0] h_next_s;
      logic [N_HIDDEN-1:0] h_q_r;
      logic                v1_r;

      for (genvar k = 0; k < N_HIDDEN; k++) begin : g_hn
        assign h_next_s[k] = fire_hidden(chain_r[k*NB_H +: N_IN],
                                         chain_r[k*NB_H + N_IN +: TW_H],
                                         x_q_r);
      end

      // Stage 1: hidden activations, loaded only behind a valid stage-0 vector.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          h_q_r <= {N_HIDDEN{1'b0}};
          v1_r  <= 1'b0;
        end else if (setup) begin
          v1_r  <= 1'b0;
        end else begin
          v1_r <= v0_r;
          if (v0_r) begin
            h_q_r <= h_next_s;
          end
        end
      end

      assign o_in_s  = h_q_r;
      assign o_vin_s = v1_r;
    end else begin : g_bypass
      // Single-layer build: output neurons read the stage-0 register.
      assign o_in_s  = x_q_r;
      assign o_vin_s = v0_r;
    end
  endgenerate

  for (genvar j = 0; j < N_OUT; j++) begin : g_on
    assign y_next_s[j] = fire_output(chain_r[OBASE + j*NB_O +: FI_O],
                                     chain_r[OBASE + j*NB_O + FI_O +: TW_O],
                                     o_in_s);
  end

  // Output stage: y updates only for a valid vector and holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_r         <= {N_OUT{1'b0}};
      out_valid_r <= 1'b0;
    end else if (setup) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= o_vin_s;
      if (o_vin_s) begin
        y_r <= y_next_s;
      end
    end
  end

endmodule

// File: tb/tb_bnn_pipelined_core.sv
// Testbench for bnn_pipelined_core: a two-layer build (N_IN=4, N_HIDDEN=2,
// N_OUT=2, 22 chain bits) and a single-layer build (N_IN=4, N_HIDDEN=0,
// N_OUT=1, 7 chain bits) share one clock and reset.
module tb_bnn_pipelined_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       setup_a, param_in_a, param_out_a, in_valid_a, out_valid_a, cfg_done_a;
  logic [3:0] x_a;
  logic [1:0] y_a;
  logic       setup_b, param_in_b, param_out_b, in_valid_b, out_valid_b, cfg_done_b;
  logic [3:0] x_b;
  logic [0:0] y_b;

  bnn_pipelined_core #(.N_IN(4), .N_HIDDEN(2), .N_OUT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .setup(setup_a), .param_in(param_in_a),
    .param_out(param_out_a), .in_valid(in_valid_a), .x(x_a),
    .out_valid(out_valid_a), .y(y_a), .cfg_done(cfg_done_a)
  );

  bnn_pipelined_core #(.N_IN(4), .N_HIDDEN(0), .N_OUT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .setup(setup_b), .param_in(param_in_b),
    .param_out(param_out_b), .in_valid(in_valid_b), .x(x_b),
    .out_valid(out_valid_b), .y(y_b), .cfg_done(cfg_done_b)
  );

  typedef struct {
    logic [3:0] x;
    logic [1:0] y;
  } tv_t;

  typedef struct {
    int         due;
    logic [1:0] y;
  } pend_t;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] ya_exp;
  logic       yb_exp;
  tv_t        tbl [5];
  logic [21:0] cfg3;
  logic [21:0] cfg_bd;
  logic [21:0] pat;
  logic [21:0] rc;
  logic [6:0]  rcb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [21:0] mk_cfg(input logic [2:0] h0t, input logic [3:0] h0w,
                                         input logic [2:0] h1t, input logic [3:0] h1w,
                                         input logic [1:0] o0t, input logic [1:0] o0w,
                                         input logic [1:0] o1t, input logic [1:0] o1w);
    return {o1t, o1w, o0t, o0w, h1t, h1w, h0t, h0w};
  endfunction

  // Reference: count agreeing bits per neuron, compare against the threshold.
  function automatic logic [1:0] model_a(input logic [21:0] c, input logic [3:0] xv);
    int hits;
    int thr;
    logic [1:0] h;
    logic [1:0] o;
    for (int k = 0; k < 2; k++) begin
      hits = 0;
      for (int i = 0; i < 4; i++) if (c[k*7 + i] == xv[i]) hits++;
      thr  = int'(c[k*7 + 4 +: 3]);
      h[k] = (hits >= thr);
    end
    for (int j = 0; j < 2; j++) begin
      hits = 0;
      for (int i = 0; i < 2; i++) if (c[14 + j*4 + i] == h[i]) hits++;
      thr  = int'(c[14 + j*4 + 2 +: 2]);
      o[j] = (hits >= thr);
    end
    return o;
  endfunction

  function automatic logic model_b(input logic [6:0] c, input logic [3:0] xv);
    int hits;
    hits = 0;
    for (int i = 0; i < 4; i++) if (c[i] == xv[i]) hits++;
    return (hits >= int'(c[6:4]));
  endfunction

  task automatic load_a(input logic [21:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      param_in_a = v[21-i];
      tick();
    end
  endtask

  task automatic load_b(input logic [6:0] v);
    for (int i = 0; i < 7; i++) begin
      param_in_b = v[6-i];
      tick();
    end
  endtask

  // Stream the table back-to-back; each result is due on the third edge.
  task automatic run_table(input string tag);
    for (int e = 1; e <= 7; e++) begin
      if (e <= 5) begin
        in_valid_a = 1'b1;
        x_a        = tbl[e-1].x;
      end else begin
        in_valid_a = 1'b0;
      end
      tick();
      if (e >= 3) begin
        chk({tag, "_ov"}, out_valid_a, 1'b1);
        chk({tag, "_y"}, y_a, tbl[e-3].y);
      end else begin
        chk({tag, "_ov_early"}, out_valid_a, 1'b0);
      end
    end
    ya_exp = tbl[4].y;
  endtask

  task automatic rand_run_a(input logic [21:0] c, input int ncyc);
    pend_t q[$];
    pend_t p;
    for (int e = 1; e <= ncyc; e++) begin
      in_valid_a = (e <= ncyc - 3) ? ($urandom_range(0, 3) != 0) : 1'b0;
      x_a        = 4'($urandom);
      if (in_valid_a) q.push_back('{e + 2, model_a(c, x_a)});
      tick();
      if (q.size() > 0 && q[0].due == e) begin
        p = q.pop_front();
        chk("rand_a_ov", out_valid_a, 1'b1);
        chk("rand_a_y", y_a, p.y);
        ya_exp = p.y;
      end else begin
        chk("rand_a_ov_idle", out_valid_a, 1'b0);
        chk("rand_a_y_hold", y_a, ya_exp);
      end
    end
  endtask

  task automatic rand_run_b(input logic [6:0] c, input int ncyc);
    pend_t q[$];
    pend_t p;
    for (int e = 1; e <= ncyc; e++) begin
      in_valid_b = (e <= ncyc - 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
      x_b        = 4'($urandom);
      if (in_valid_b) q.push_back('{e + 1, {1'b0, model_b(c, x_b)}});
      tick();
      if (q.size() > 0 && q[0].due == e) begin
        p = q.pop_front();
        chk("rand_b_ov", out_valid_b, 1'b1);
        chk("rand_b_y", y_b, p.y[0]);
        yb_exp = p.y[0];
      end else begin
        chk("rand_b_ov_idle", out_valid_b, 1'b0);
        chk("rand_b_y_hold", y_b, yb_exp);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b1111, 2'b01};
    tbl[1] = '{4'b0000, 2'b11};
    tbl[2] = '{4'b0101, 2'b00};
    tbl[3] = '{4'b1000, 2'b00};
    tbl[4] = '{4'b0000, 2'b11};
    cfg3   = mk_cfg(3'd4, 4'b1111, 3'd4, 4'b0000, 2'd1, 2'b11, 2'd2, 2'b10);
    cfg_bd = mk_cfg(3'd7, 4'b1111, 3'd0, 4'b0000, 2'd3, 2'b11, 2'd0, 2'b00);
    pat    = 22'h2D5A3C;

    rst_n = 1'b0;
    setup_a = 1'b0; param_in_a = 1'b0; in_valid_a = 1'b0; x_a = 4'b0000;
    setup_b = 1'b0; param_in_b = 1'b0; in_valid_b = 1'b0; x_b = 4'b0000;
    @(negedge clk);
    tick();
    tick();
    chk("rst_y_a", y_a, 2'b00);
    chk("rst_ov_a", out_valid_a, 1'b0);
    chk("rst_done_a", cfg_done_a, 1'b0);
    chk("rst_pout_a", param_out_a, 1'b0);
    chk("rst_y_b", y_b, 1'b0);
    chk("rst_ov_b", out_valid_b, 1'b0);
    rst_n = 1'b1;

    // Zero chain: every neuron fires, result on the third edge.
    in_valid_a = 1'b1; x_a = 4'b0101;
    tick();
    in_valid_a = 1'b0;
    chk("t1_ov_e1", out_valid_a, 1'b0);
    tick();
    chk("t1_ov_e2", out_valid_a, 1'b0);
    tick();
    chk("t1_ov_e3", out_valid_a, 1'b1);
    chk("t1_y_e3", y_a, 2'b11);
    tick();
    chk("t1_ov_e4", out_valid_a, 1'b0);
    chk("t1_y_hold", y_a, 2'b11);
    ya_exp = 2'b11;

    // Shift 22 bits, then 22 more while the first 22 replay on param_out.
    setup_a = 1'b1;
    for (int i = 0; i < 22; i++) begin
      param_in_a = pat[21-i];
      tick();
      chk("t2_done", cfg_done_a, (i == 21));
    end
    for (int i = 0; i < 22; i++) begin
      chk("t2_replay", param_out_a, pat[21-i]);
      param_in_a = cfg3[21-i];
      tick();
      chk("t2_done_hold", cfg_done_a, 1'b1);
    end
    setup_a = 1'b0;
    tick();
    chk("t2_done_after", cfg_done_a, 1'b1);
    chk("t2_ov_idle", out_valid_a, 1'b0);

    run_table("t3");

    // Setup one cycle after two injections: both vectors are dropped.
    in_valid_a = 1'b1; x_a = 4'b1111;
    tick();
    x_a = 4'b0000;
    tick();
    in_valid_a = 1'b0; setup_a = 1'b1; param_in_a = 1'b0;
    tick();
    setup_a = 1'b0;
    chk("t4_new_session", cfg_done_a, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_ov", out_valid_a, 1'b0);
      chk("t4_y_hold", y_a, ya_exp);
      tick();
    end

    // Reset part-way through a load.
    setup_a = 1'b1;
    load_a(cfg3, 10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; setup_a = 1'b0;
    chk("t5_done", cfg_done_a, 1'b0);
    chk("t5_pout", param_out_a, 1'b0);
    chk("t5_y_rst", y_a, 2'b00);
    in_valid_a = 1'b1; x_a = 4'b0110;
    tick();
    in_valid_a = 1'b0;
    tick();
    tick();
    chk("t5_zero_ov", out_valid_a, 1'b1);
    chk("t5_zero_y", y_a, 2'b11);
    setup_a = 1'b1;
    load_a(cfg3, 22);
    setup_a = 1'b0;
    chk("t5_reload_done", cfg_done_a, 1'b1);
    run_table("t5");

    // Threshold extremes: thr above fan-in never fires, thr 0 always fires.
    setup_a = 1'b1;
    load_a(cfg_bd, 22);
    setup_a = 1'b0;
    in_valid_a = 1'b1; x_a = 4'b1111;
    tick();
    x_a = 4'b0000;
    tick();
    in_valid_a = 1'b0;
    tick();
    chk("bd_ov1", out_valid_a, 1'b1);
    chk("bd_y1", y_a, 2'b10);
    tick();
    chk("bd_ov2", out_valid_a, 1'b1);
    chk("bd_y2", y_a, 2'b10);
    tick();
    chk("bd_ov3", out_valid_a, 1'b0);
    ya_exp = 2'b10;

    for (int r = 0; r < 4; r++) begin
      rc = 22'($urandom);
      setup_a = 1'b1;
      load_a(rc, 22);
      setup_a = 1'b0;
      rand_run_a(rc, 60);
    end

    // Single-layer build: two-edge latency.
    yb_exp  = 1'b0;
    setup_b = 1'b1;
    load_b(7'b011_1010);
    setup_b = 1'b0;
    chk("t6_done", cfg_done_b, 1'b1);
    in_valid_b = 1'b1; x_b = 4'b1010;
    tick();
    in_valid_b = 1'b0;
    chk("t6_ov_e1", out_valid_b, 1'b0);
    tick();
    chk("t6_ov_a", out_valid_b, 1'b1);
    chk("t6_y_a", y_b, 1'b1);
    in_valid_b = 1'b1; x_b = 4'b0101;
    tick();
    in_valid_b = 1'b0;
    chk("t6_ov_e1b", out_valid_b, 1'b0);
    chk("t6_y_hold", y_b, 1'b1);
    tick();
    chk("t6_ov_b", out_valid_b, 1'b1);
    chk("t6_y_b", y_b, 1'b0);
    yb_exp = 1'b0;

    for (int r = 0; r < 3; r++) begin
      rcb = 7'($urandom);
      setup_b = 1'b1;
      load_b(rcb);
      setup_b = 1'b0;
      rand_run_b(rcb, 40);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
